// File: rtl/result_display_pkg.sv
// rtl/result_display_pkg.sv - shared types and constants for the result display
package result_display_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int BCD_DIGITS = 3;

   // Active-low segments {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;

   // Double-dabble correction: any digit >= 5 gets +3 before the shift
   function automatic logic [BCD_DIGITS*4-1:0] dabble_adjust(input logic [BCD_DIGITS*4-1:0] s);
      logic [BCD_DIGITS*4-1:0] r;
      r = s;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (s[i*4 +: 4] >= 4'd5)
            r[i*4 +: 4] = s[i*4 +: 4] + 4'd3;
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// rtl/bcd_to_seg.sv - combinational BCD digit to active-low 7-segment decode
module bcd_to_seg
   import result_display_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (digit)
         4'd0: seg = SEG_0;
         4'd1: seg = SEG_1;
         4'd2: seg = SEG_2;
         4'd3: seg = SEG_3;
         4'd4: seg = SEG_4;
         4'd5: seg = SEG_5;
         4'd6: seg = SEG_6;
         4'd7: seg = SEG_7;
         4'd8: seg = SEG_8;
         4'd9: seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/result_display.sv
// rtl/result_display.sv - 9-bit binary to BCD converter with multiplexed 3-digit display
module result_display
   import result_display_pkg::*;
#(
   parameter int SCAN_DIV = 50000
)
(
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [8:0]  value,
   output logic        busy,
   output logic        done,
   output logic [11:0] bcd,
   output logic [6:0]  seg,
   output logic [2:0]  an
);

   localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

   state_t      state;
   logic [8:0]  shreg;
   logic [11:0] scratch;
   logic [11:0] adj;
   logic [3:0]  bitcnt;

   assign adj = dabble_adjust(scratch);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         bcd     <= 12'h000;
         shreg   <= 9'd0;
         scratch <= 12'h000;
         bitcnt  <= 4'd0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  shreg   <= value;
                  scratch <= 12'h000;
                  bitcnt  <= 4'd9;
                  busy    <= 1'b1;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               {scratch, shreg} <= {adj[10:0], shreg, 1'b0};
               bitcnt <= bitcnt - 4'd1;
               if (bitcnt == 4'd1)
                  state <= DONE;
            end
            DONE: begin
               bcd   <= scratch;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Display scan: outputs are registered from the next digit index so an and seg stay aligned
   logic [15:0] scan_cnt;
   logic [1:0]  idx;
   logic [1:0]  idx_n;
   logic        scan_wrap;
   logic [3:0]  sel_digit;
   logic        blank;
   logic [2:0]  an_n;
   logic [6:0]  dec_seg;

   assign scan_wrap = (scan_cnt == SCAN_LAST);

   always_comb begin
      idx_n = idx;
      if (scan_wrap)
         idx_n = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
   end

   always_comb begin
      sel_digit = bcd[3:0];
      blank     = 1'b0;
      an_n      = 3'b110;
      case (idx_n)
         2'd1: begin
            sel_digit = bcd[7:4];
            blank     = (bcd[11:4] == 8'h00);
            an_n      = 3'b101;
         end
         2'd2: begin
            sel_digit = bcd[11:8];
            blank     = (bcd[11:8] == 4'h0);
            an_n      = 3'b011;
         end
         default: begin
            sel_digit = bcd[3:0];
            blank     = 1'b0;
            an_n      = 3'b110;
         end
      endcase
   end

   bcd_to_seg u_dec (
      .digit (sel_digit),
      .seg   (dec_seg)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         scan_cnt <= 16'd0;
         idx      <= 2'd0;
         an       <= 3'b110;
         seg      <= SEG_0;
      end else begin
         scan_cnt <= scan_wrap ? 16'd0 : scan_cnt + 16'd1;
         idx      <= idx_n;
         an       <= an_n;
         seg      <= blank ? SEG_BLANK : dec_seg;
      end
   end

endmodule

// File: tb/tb_result_display.sv
// tb/tb_result_display.sv - directed self-checking bench for result_display
module tb_result_display;

   logic        clock;
   logic        reset;
   logic        start;
   logic [8:0]  value;
   logic        busy;
   logic        done;
   logic [11:0] bcd;
   logic [6:0]  seg;
   logic [2:0]  an;

   int checks = 0;
   int errors = 0;

   result_display #(.SCAN_DIV(4)) dut (
      .clock (clock),
      .reset (reset),
      .start (start),
      .value (value),
      .busy  (busy),
      .done  (done),
      .bcd   (bcd),
      .seg   (seg),
      .an    (an)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [8:0]  v;
      logic [11:0] b;
      logic [6:0]  su;
      logic [6:0]  st;
      logic [6:0]  sh;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [11:0] to_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   // Called just after a falling edge: start is sampled on the next rising edge (edge k)
   task automatic convert(input logic [8:0] v, input logic [11:0] exp);
      logic [11:0] bseq;
      logic [11:0] dseq;
      start = 1'b1;
      value = v;
      for (int c = 0; c < 12; c++) begin
         @(negedge clock);
         start = 1'b0;
         bseq[c] = busy;
         dseq[c] = done;
         if (c == 10)
            check($sformatf("bcd_%0d", v), 32'(bcd), 32'(exp));
      end
      check($sformatf("busy_seq_%0d", v), 32'(bseq), 32'h3ff);
      check($sformatf("done_seq_%0d", v), 32'(dseq), 32'h400);
   endtask

   task automatic scan_check(input vec_t t);
      logic [2:0] prev;
      logic [2:0] exp_an;
      logic [6:0] exp_seg;
      logic       found;
      int         bad;
      found = 1'b0;
      prev  = an;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clock);
         if (an == 3'b110 && prev == 3'b011)
            found = 1'b1;
         prev = an;
      end
      check($sformatf("scan_sync_%0d", t.v), 32'(found), 32'd1);
      bad = 0;
      for (int i = 0; i < 12; i++) begin
         if (i > 0) @(negedge clock);
         exp_an  = (i < 4) ? 3'b110 : (i < 8) ? 3'b101 : 3'b011;
         exp_seg = (i < 4) ? t.su : (i < 8) ? t.st : t.sh;
         if (an !== exp_an) bad++;
         if (i % 4 == 0)
            check($sformatf("seg_%0d_digit%0d", t.v, i / 4), 32'(seg), 32'(exp_seg));
      end
      check($sformatf("an_pattern_%0d", t.v), 32'(bad), 32'd0);
   endtask

   initial begin
      int dcount;

      vecs[0] = '{9'd511, 12'h511, 7'b1111001, 7'b1111001, 7'b0010010};
      vecs[1] = '{9'd7,   12'h007, 7'b1111000, 7'b1111111, 7'b1111111};
      vecs[2] = '{9'd0,   12'h000, 7'b1000000, 7'b1111111, 7'b1111111};
      vecs[3] = '{9'd100, 12'h100, 7'b1000000, 7'b1000000, 7'b1111001};
      vecs[4] = '{9'd99,  12'h099, 7'b0010000, 7'b0010000, 7'b1111111};
      vecs[5] = '{9'd10,  12'h010, 7'b1000000, 7'b1111001, 7'b1111111};
      vecs[6] = '{9'd256, 12'h256, 7'b0000010, 7'b0010010, 7'b0100100};
      vecs[7] = '{9'd305, 12'h305, 7'b0010010, 7'b1000000, 7'b0110000};

      reset = 1'b0;
      start = 1'b0;
      value = 9'd0;
      repeat (3) @(negedge clock);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_bcd",  32'(bcd),  32'h000);
      check("rst_an",   32'(an),   32'b110);
      check("rst_seg",  32'(seg),  32'b1000000);

      // First start accepted on the first edge after release
      reset = 1'b1;
      for (int i = 0; i < 8; i++) begin
         convert(vecs[i].v, vecs[i].b);
         scan_check(vecs[i]);
         @(negedge clock);
      end

      // Value changes while idle do not disturb the held result
      value = 9'd123;
      repeat (3) @(negedge clock);
      value = 9'd44;
      repeat (3) @(negedge clock);
      check("hold_bcd", 32'(bcd), 32'h305);

      // Start while busy is ignored
      start = 1'b1;
      value = 9'd256;
      @(negedge clock);
      start = 1'b0;
      repeat (2) @(negedge clock);
      start = 1'b1;
      value = 9'd99;
      @(negedge clock);
      start = 1'b0;
      dcount = 0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clock);
         if (done) dcount++;
      end
      check("busy_ignore_done_count", 32'(dcount), 32'd1);
      check("busy_ignore_bcd", 32'(bcd), 32'h256);
      check("busy_ignore_idle", 32'(busy), 32'd0);
      convert(9'd99, 12'h099);
      scan_check(vecs[4]);

      // Reset in the middle of a conversion
      @(negedge clock);
      start = 1'b1;
      value = 9'd300;
      @(negedge clock);
      start = 1'b0;
      repeat (4) @(negedge clock);
      #2 reset = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_bcd",  32'(bcd),  32'h000);
      check("midrst_an",   32'(an),   32'b110);
      check("midrst_seg",  32'(seg),  32'b1000000);
      @(negedge clock);
      reset = 1'b1;
      dcount = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clock);
         if (done) dcount++;
      end
      check("midrst_no_done", 32'(dcount), 32'd0);
      check("midrst_bcd_after", 32'(bcd), 32'h000);
      scan_check(vecs[2]);

      // Full sweep
      @(negedge clock);
      for (int v = 0; v < 512; v++) begin
         convert(9'(v), to_bcd(v));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
